// File: rtl/gauss_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gauss_pkg
//  Description : Shared pixel width, pixel type, sequencer states and push
//                metadata for the Gaussian stream controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package gauss_pkg;

    localparam int DW = 8;

    typedef logic [DW-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        PAD   = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Per-push window metadata, travels one cycle behind the column data
    typedef struct packed {
        logic keep;
        logic top_e;
        logic bot_e;
        logic left_e;
        logic right_e;
        logic last;
    } meta_t;

endpackage
`default_nettype wire

// File: rtl/gauss_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : gauss_stream_ctrl_if
//  Description : Pixel input stream plus kernel column/edge outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gauss_stream_ctrl_if #(
    parameter int DW = gauss_pkg::DW
);
    logic [DW-1:0] s_pixel;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] k_top;
    logic [DW-1:0] k_mid;
    logic [DW-1:0] k_bot;
    logic          k_valid;
    logic          k_top_edge;
    logic          k_bot_edge;
    logic          k_left_edge;
    logic          k_right_edge;
    logic          k_keep;

    // Controller side: consumes the pixel stream, drives the kernel
    modport slave (
        input  s_pixel, s_valid,
        output s_ready, k_top, k_mid, k_bot, k_valid,
        output k_top_edge, k_bot_edge, k_left_edge, k_right_edge, k_keep
    );

    // Source/observer side
    modport master (
        output s_pixel, s_valid,
        input  s_ready, k_top, k_mid, k_bot, k_valid,
        input  k_top_edge, k_bot_edge, k_left_edge, k_right_edge, k_keep
    );
endinterface
`default_nettype wire

// File: rtl/gauss_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : gauss_line_buf
//  Description : Two IMG_W-deep pixel rows, combinational read at col and a
//                shift write (row1 <= row0, row0 <= din) on wr_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module gauss_line_buf #(
    parameter int IMG_W = 64,
    parameter int DW    = 8,
    parameter int CW    = $clog2(IMG_W)
) (
    input  wire          clk,
    input  wire [CW-1:0] col,
    input  wire          wr_en,
    input  wire          fill,
    input  wire [DW-1:0] din,
    output logic [DW-1:0] top,
    output logic [DW-1:0] mid
);

    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];

    // During fill both rows take the pixel so no stale data from an earlier frame survives
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb1[col] <= fill ? din : lb0[col];
            lb0[col] <= din;
        end
    end

    assign top = lb1[col];
    assign mid = lb0[col];

endmodule
`default_nettype wire

// File: rtl/gauss_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gauss_stream_ctrl
//  Description : Raster sequencer feeding a 3x3 Gaussian kernel: row buffers,
//                right-pad and bottom-flush pushes, edge flags and keep.
//  Revision    : 1.0 - initial release
// ============================================================================
module gauss_stream_ctrl
    import gauss_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = gauss_pkg::DW
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  start,
    gauss_stream_ctrl_if.slave bus,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(IMG_W);
    localparam int PW = CW + 1;
    localparam int RW = $clog2(IMG_H + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [PW-1:0] P_LAST    = PW'(IMG_W);
    localparam logic [PW-1:0] P_FIRST   = PW'(1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FLUSH = RW'(IMG_H);

    state_t          state, state_nx;
    logic [CW-1:0]   col, col_nx;
    logic [RW-1:0]   row, row_nx;
    logic            ready, accept, push, lb_we, lb_fill;
    logic [DW-1:0]   lb_top, lb_mid;
    logic [DW-1:0]   push_top, push_mid, push_bot;
    logic [PW-1:0]   p;
    meta_t           meta, meta_d;
    logic [DW-1:0]   top_q, mid_q, bot_q;
    logic            valid_q, keep_q, te_q, be_q, le_q, re_q;

    gauss_line_buf #(
        .IMG_W (IMG_W),
        .DW    (DW),
        .CW    (CW)
    ) u_line_buf (
        .clk   (clk),
        .col   (col),
        .wr_en (lb_we),
        .fill  (lb_fill),
        .din   (bus.s_pixel),
        .top   (lb_top),
        .mid   (lb_mid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nx;
            col   <= col_nx;
            row   <= row_nx;
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        ready    = (state == FILL) || (state == RUN);
        accept   = ready & bus.s_valid;
        push     = 1'b0;
        lb_we    = 1'b0;
        lb_fill  = 1'b0;
        push_top = '0;
        push_mid = '0;
        push_bot = '0;
        p        = '0;
        meta     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FILL;
                    col_nx   = '0;
                    row_nx   = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    lb_we   = 1'b1;
                    lb_fill = 1'b1;
                    if (col == COL_LAST) begin
                        col_nx   = '0;
                        row_nx   = ROW_ONE;
                        state_nx = RUN;
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    push     = 1'b1;
                    lb_we    = 1'b1;
                    push_top = lb_top;
                    push_mid = lb_mid;
                    push_bot = bus.s_pixel;
                    p        = {1'b0, col};
                    if (col == COL_LAST) begin
                        col_nx   = '0;
                        state_nx = PAD;
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end
            PAD: begin
                push   = 1'b1;
                p      = P_LAST;
                row_nx = row + 1'b1;
                if (row == ROW_FLUSH) begin
                    state_nx  = DONE;
                    row_nx    = '0;
                    meta.last = 1'b1;
                end else if (row == ROW_LAST) begin
                    state_nx = FLUSH;
                end else begin
                    state_nx = RUN;
                end
            end
            FLUSH: begin
                push     = 1'b1;
                push_top = lb_top;
                push_mid = lb_mid;
                p        = {1'b0, col};
                if (col == COL_LAST) begin
                    col_nx   = '0;
                    state_nx = PAD;
                end else begin
                    col_nx = col + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Push p centres the window on column p-1 of row-1; p=0 only primes the kernel
        if (push && (p != '0)) begin
            meta.keep    = 1'b1;
            meta.top_e   = (row == ROW_ONE);
            meta.bot_e   = (row == ROW_FLUSH);
            meta.left_e  = (p == P_FIRST);
            meta.right_e = (p == P_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
            meta_d  <= '0;
            keep_q  <= 1'b0;
            te_q    <= 1'b0;
            be_q    <= 1'b0;
            le_q    <= 1'b0;
            re_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            valid_q <= push;
            if (push) begin
                top_q <= push_top;
                mid_q <= push_mid;
                bot_q <= push_bot;
            end
            meta_d <= meta;
            // Flags line up with the kernel output, one cycle after k_valid
            if (valid_q) begin
                keep_q <= meta_d.keep;
                te_q   <= meta_d.top_e;
                be_q   <= meta_d.bot_e;
                le_q   <= meta_d.left_e;
                re_q   <= meta_d.right_e;
            end
            done <= valid_q & meta_d.last;
            if ((state == IDLE) && start) begin
                busy <= 1'b1;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
        end
    end

    assign bus.s_ready      = ready;
    assign bus.k_valid      = valid_q;
    assign bus.k_top        = top_q;
    assign bus.k_mid        = mid_q;
    assign bus.k_bot        = bot_q;
    assign bus.k_keep       = keep_q;
    assign bus.k_top_edge   = te_q;
    assign bus.k_bot_edge   = be_q;
    assign bus.k_left_edge  = le_q;
    assign bus.k_right_edge = re_q;

endmodule
`default_nettype wire
